weight_buffer_stream: RTL
=========================

// Module: weight_buffer_stream
// PURPOSE
//  Loadable, multi-bank weight store that streams packed weight words to the fixed-point MAC array.
//  Successor to the fixed ROM weight buffers: bank count, lane count, depth and width are parametrised, and weights are loadable at run time.
//  Replaces free-running index addressing with a start/count burst engine, address wrap and valid/ready backpressure.
//  Sits between the weight loader (load port) and the LSTM gate MAC stage (stream port).
// PARAMETERS
//  DATA_WIDTH  18  bits per weight lane
//  LANES       9   weights per word per bank
//  BANKS       2   parallel banks, read in lock-step
//  DEPTH       42  words per bank; index range 0..DEPTH-1
//  ADDR_WIDTH  12  index/count width; DEPTH <= 2**ADDR_WIDTH
//  FIFO_DEPTH  4   output FIFO entries; must be >= 3
// PORTS
//  clk          in   1                          single clock, rising edge
//  rst_n        in   1                          asynchronous, active-low reset
//  ld_valid     in   1                          load-word request
//  ld_ready     out  1                          load accepted when ld_valid && ld_ready
//  ld_bank      in   clog2(BANKS)               target bank
//  ld_addr      in   ADDR_WIDTH                 target word
//  ld_data      in   LANES*DATA_WIDTH           packed word; lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//  start        in   1                          burst request; sampled only in IDLE
//  start_index  in   ADDR_WIDTH                 first word of the burst
//  count        in   ADDR_WIDTH                 number of beats
//  q            out  BANKS*LANES*DATA_WIDTH     bank b, lane k at [(b*LANES+k)*DATA_WIDTH +: DATA_WIDTH]
//  q_valid      out  1                          beat available
//  q_ready      in   1                          consumer accepts; a beat transfers on q_valid && q_ready
//  q_last       out  1                          qualifies the final beat of the burst
//  busy         out  1                          high outside IDLE
//  done         out  1                          1-cycle pulse after the last beat transfers (or for an empty burst)
//  err          out  1                          1-cycle pulse when a start is rejected
// BEHAVIOUR
//  Reset values: ld_ready=1; q_valid, q_last, busy, done, err = 0; q = 0.
//   FSM returns to IDLE; FIFO and counters clear. RAM contents are not reset.
//  FSM states and transitions:
//   IDLE: start with count==0 -> done pulse next cycle, stay IDLE.
//    start with start_index>=DEPTH -> err pulse, stay IDLE.
//    Otherwise latch addr=start_index, remaining=count -> ISSUE.
//   ISSUE: one read per cycle to all banks at addr when fifo_count + inflight < FIFO_DEPTH.
//    Each issue: addr wraps DEPTH-1 -> 0, remaining decrements. Last issue -> DRAIN.
//   DRAIN: wait until the last beat transfers; done pulses the following cycle; -> IDLE.
//  Load port:
//   ld_ready = (state==IDLE). An accepted load writes RAM[ld_bank][ld_addr] on that edge.
//   ld_addr>=DEPTH is dropped silently.
//   start and ld_valid in the same IDLE cycle: the load is performed and the start is also accepted.
//   Read-after-write on the same address returns the new data.
//  Read latency:
//   Read address is registered, then RAM output is registered, then written to the FIFO.
//   With q_ready=1, the first q_valid appears 3 cycles after the edge that samples start.
//   Steady state is 1 beat/cycle, so a burst of N beats takes N+3 cycles to complete.
//  Backpressure: q, q_valid and q_last hold stable while q_valid && !q_ready.
//   No beat is dropped, duplicated or reordered. The credit rule guarantees the FIFO never overflows.
//  start while busy: ignored; no err pulse.
//  rst_n asserted mid-burst: outputs drop asynchronously to their reset values. The in-flight burst is discarded.
// STRUCTURE
//  Package weight_buffer_pkg holds:
//   the FSM state enum (IDLE/ISSUE/DRAIN)
//   the localparams WORD_W = LANES*DATA_WIDTH, PACK_W = BANKS*WORD_W, BANK_SEL_W
//   the lane/bank slice helper functions.
//  Banks: BANKS instances of the existing single_port_ram, with DATA_WIDTH=WORD_W.
//   The write-enable is muxed from the load port, the address from the FSM or the load port.
//  One sub-module: weight_stream_fifo.
//   Synchronous FIFO, PACK_W+1 bits wide with q_last stored alongside the data.
//   FIFO_DEPTH entries, registered outputs, exports its count.
// TESTING
//  Sequence 1: load bank0 word i = {LANES{i}}, bank1 word i = {LANES{i+100}}.
//   Then start(index 0, count 42) with q_ready=1.
//   Expect 42 beats in order, first q_valid at cycle 3, q_last on beat 42, done 1 cycle later.
//  Wrap: start(index 40, count 5) -> bank0 lane0 sequence 40, 41, 0, 1, 2; q_last on the fifth beat.
//  Backpressure: q_ready toggles every cycle during count=20 -> the same 20 beats in order.
//   Held data stays stable while stalled, FIFO count never exceeds 4, done 1 cycle after the final beat.
//  Corners:
//   start count=0 -> done pulse, no q_valid.
//   start index 42 -> err pulse, busy stays 0.
//   start while busy -> ignored.
//   ld_valid during ISSUE -> ld_ready=0 and RAM unchanged.
//  Reset: assert rst_n low at beat 10 of a 30-beat burst.
//   Expect q_valid and busy to drop immediately and ld_ready=1 after release.
//   A new start(0,3) then returns the previously loaded data.

Source files
------------

// File: rtl/weight_buffer_pkg.sv
// Shared types, default geometry and slice helpers for the weight buffer stream.
package weight_buffer_pkg;

  // Default geometry of the shipped weight buffer.
  localparam int DEF_DATA_WIDTH = 18;
  localparam int DEF_LANES      = 9;
  localparam int DEF_BANKS      = 2;
  localparam int DEF_DEPTH      = 42;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam int WORD_W     = DEF_LANES * DEF_DATA_WIDTH;
  localparam int PACK_W     = DEF_BANKS * WORD_W;
  localparam int BANK_SEL_W = (DEF_BANKS > 1) ? $clog2(DEF_BANKS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One weight lane out of a packed multi-bank beat.
  function automatic logic [DEF_DATA_WIDTH-1:0] get_lane(input logic [PACK_W-1:0] pack,
                                                         input int bank, input int lane);
    return pack[(bank * DEF_LANES + lane) * DEF_DATA_WIDTH +: DEF_DATA_WIDTH];
  endfunction

  // One bank's word out of a packed multi-bank beat.
  function automatic logic [WORD_W-1:0] get_bank_word(input logic [PACK_W-1:0] pack,
                                                      input int bank);
    return pack[bank * WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/single_port_ram.sv
// Generic single-port RAM with synchronous write and registered (read-first) output.
module single_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write on we, register the addressed word every cycle.
  // NOTE: the storage array has no reset so it maps onto RAM macros; only control state is reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/weight_stream_fifo.sv
// Synchronous FIFO with a registered output stage; count covers storage plus the output register.
module weight_stream_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] arr_count;
  logic             pop, load_out, arr_empty, take_arr, push_arr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop       = rd_valid && rd_ready;
  assign load_out  = !rd_valid || pop;
  assign arr_empty = (arr_count == '0);
  assign take_arr  = load_out && !arr_empty;
  // A write bypasses storage when the output register is free and nothing is queued ahead of it.
  assign push_arr  = wr_valid && !(load_out && arr_empty);
  assign count     = arr_count + CNT_W'(rd_valid);

  // Storage array write.
  always_ff @(posedge clk) begin
    if (push_arr) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      arr_count <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      if (push_arr) wr_ptr <= next_ptr(wr_ptr);
      if (take_arr) rd_ptr <= next_ptr(rd_ptr);
      arr_count <= arr_count + CNT_W'(push_arr) - CNT_W'(take_arr);
      if (load_out) begin
        if (!arr_empty) begin
          rd_data  <= mem[rd_ptr];
          rd_valid <= 1'b1;
        end else if (wr_valid) begin
          rd_data  <= wr_data;
          rd_valid <= 1'b1;
        end else begin
          rd_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/weight_buffer_stream.sv
// Loadable multi-bank weight store streaming packed words to the MAC array in start/count bursts.
module weight_buffer_stream
  import weight_buffer_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int LANES      = DEF_LANES,
  parameter  int BANKS      = DEF_BANKS,
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int BSEL_W     = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                ld_valid,
  output logic                                ld_ready,
  input  logic [BSEL_W-1:0]                   ld_bank,
  input  logic [ADDR_WIDTH-1:0]               ld_addr,
  input  logic [LANES*DATA_WIDTH-1:0]         ld_data,
  input  logic                                start,
  input  logic [ADDR_WIDTH-1:0]               start_index,
  input  logic [ADDR_WIDTH-1:0]               count,
  output logic [BANKS*LANES*DATA_WIDTH-1:0]   q,
  output logic                                q_valid,
  input  logic                                q_ready,
  output logic                                q_last,
  output logic                                busy,
  output logic                                done,
  output logic                                err
);

  localparam int WORD_BITS = LANES * DATA_WIDTH;
  localparam int PACK_BITS = BANKS * WORD_BITS;
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  rd_addr, remaining;
  logic [IDX_W-1:0]       ram_idx;
  logic [PACK_BITS-1:0]   ram_rdata, s2_data;
  logic [PACK_BITS:0]     fifo_out;
  logic [CNT_W-1:0]       fifo_count;
  logic [1:0]             inflight;
  logic                   s1_valid, s1_last, s2_valid, s2_last;
  logic                   ld_fire, issue;

  assign ld_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign ld_fire  = ld_valid && ld_ready && (ld_addr < DEPTH_A);
  assign inflight = {1'b0, s1_valid} + {1'b0, s2_valid};
  // Credit: never have more beats queued or in the read pipeline than the FIFO can hold.
  assign issue    = (state == ISSUE) &&
                    (({1'b0, fifo_count} + (CNT_W+1)'(inflight)) < (CNT_W+1)'(FIFO_DEPTH));
  // Loads own the RAM port in IDLE; bursts own it otherwise.
  assign ram_idx  = (state == IDLE) ? ld_addr[IDX_W-1:0] : rd_addr[IDX_W-1:0];

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic bank_we;
    assign bank_we = ld_fire && (ld_bank == BSEL_W'(b));
    single_port_ram #(
      .DATA_WIDTH (WORD_BITS),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (IDX_W)
    ) u_ram (
      .clk   (clk),
      .we    (bank_we),
      .addr  (ram_idx),
      .wdata (ld_data),
      .rdata (ram_rdata[b*WORD_BITS +: WORD_BITS])
    );
  end

  // Burst control: accept/reject starts, issue one read per credit, finish on the last transfer.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_addr   <= '0;
      remaining <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (count == '0) begin
              done <= 1'b1;
            end else if (start_index >= DEPTH_A) begin
              err <= 1'b1;
            end else begin
              rd_addr   <= start_index;
              remaining <= count;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            rd_addr   <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + ONE_A;
            remaining <= remaining - ONE_A;
            if (remaining == ONE_A) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (q_valid && q_ready && q_last) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read pipeline: stage 1 is the RAM read, stage 2 registers the RAM output for the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_data  <= '0;
    end else begin
      s1_valid <= issue;
      s1_last  <= issue && (remaining == ONE_A);
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      if (s1_valid) s2_data <= ram_rdata;
    end
  end

  weight_stream_fifo #(
    .WIDTH (PACK_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (s2_valid),
    .wr_data  ({s2_last, s2_data}),
    .rd_data  (fifo_out),
    .rd_valid (q_valid),
    .rd_ready (q_ready),
    .count    (fifo_count)
  );

  assign q      = fifo_out[PACK_BITS-1:0];
  assign q_last = fifo_out[PACK_BITS] && q_valid;

endmodule
